sigmoid_arbiter: RTL and testbench

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

---
 rtl/sigmoid_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_sigmoid_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: four requesters share one external sigmoid unit.
// Grants are combinational and round-robin. Issued requester ids wait in a tag queue
// until the unit returns a result. Each result is paired with its id in a response FIFO.
// A flush stops new grants until every issued sample has been accepted downstream.
// Optional build macro SIGARB_PRIORITY_EN: requester 0 has fixed priority, and
// requesters 1-3 round-robin among themselves.
module sigmoid_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [8*NREQ-1:0]    i_req_x,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_sig_in_valid,
  output logic [7:0]           o_sig_x,
  input  logic                 i_sig_out_valid,
  input  logic [15:0]          i_sig_y,
  output logic                 o_rsp_valid,
  output logic [15:0]          o_rsp_y,
  output logic [1:0]           o_rsp_id,
  input  logic                 i_rsp_ready,
  input  logic                 i_flush,
  output logic                 o_flush_done,
  output logic                 o_err
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e          state_q;
  logic            flush_done_q;
  logic            err_q, err_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;

  logic [PtrW-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [PtrW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [1:0]      tag_mem_q [DEPTH];
  logic [17:0]     rsp_mem_q [DEPTH];

  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;
  logic            tag_empty, tag_full, tag_push, tag_pop;
  logic            rsp_empty, rsp_full, rsp_push, rsp_pop;
  logic [17:0]     rsp_head;

  // Queue status; the extra pointer bit separates full from empty
  assign tag_empty = (tag_wptr_q == tag_rptr_q);
  assign tag_full  = (tag_wptr_q[PtrW-1] != tag_rptr_q[PtrW-1]) &&
                     (tag_wptr_q[AddrW-1:0] == tag_rptr_q[AddrW-1:0]);
  assign rsp_empty = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_full  = (rsp_wptr_q[PtrW-1] != rsp_rptr_q[PtrW-1]) &&
                     (rsp_wptr_q[AddrW-1:0] == rsp_rptr_q[AddrW-1:0]);

  // Grant search: skipped in reset, in drain, or when every FIFO slot is spoken for
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    if (!rst && (state_q == StRun) && (outstanding_q != CntW'(DEPTH))) begin
`ifdef SIGARB_PRIORITY_EN
      if (i_req_valid[0]) begin
        grant_found = 1'b1;
        grant_idx   = 2'd0;
      end else begin
        for (int i = 1; i <= NREQ; i++) begin
          cand = last_grant_q + 2'(i);
          if (!grant_found && (cand != 2'd0) && i_req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
          end
        end
      end
`else
      for (int i = 1; i <= NREQ; i++) begin
        cand = last_grant_q + 2'(i);
        if (!grant_found && i_req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
`endif
    end
  end

  // One-hot ready and same-cycle issue of the granted sample
  always_comb begin
    o_req_ready    = '0;
    o_sig_in_valid = grant_found;
    o_sig_x        = 8'h00;
    if (grant_found) begin
      o_req_ready[grant_idx] = 1'b1;
      o_sig_x                = i_req_x[{grant_idx, 3'b000} +: 8];
    end
  end

  // Handshakes on the tag queue and the response FIFO
  always_comb begin
    tag_pop  = i_sig_out_valid && !tag_empty;
    tag_push = grant_found && (!tag_full || tag_pop);
    rsp_pop  = !rsp_empty && i_rsp_ready;
    rsp_push = tag_pop && (!rsp_full || rsp_pop);
  end

  // A result with no matching tag has no owner: flag it and drop it
  always_comb begin
    err_d = err_q;
    if (i_sig_out_valid && tag_empty) begin
      err_d = 1'b1;
    end
  end

  // Round-robin pointer moves only on a transfer
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_found) begin
`ifdef SIGARB_PRIORITY_EN
      // Requester 0 sits outside the rotation among 1-3
      if (grant_idx != 2'd0) begin
        last_grant_d = grant_idx;
      end
`else
      last_grant_d = grant_idx;
`endif
    end
  end

  // Outstanding count: issued samples whose responses are not yet accepted
  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant_found, rsp_pop})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Pointer advance; DEPTH is a power of two, so the natural wrap is modulo DEPTH
  always_comb begin
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    if (tag_push) tag_wptr_d = tag_wptr_q + PtrW'(1);
    if (tag_pop)  tag_rptr_d = tag_rptr_q + PtrW'(1);
    if (rsp_push) rsp_wptr_d = rsp_wptr_q + PtrW'(1);
    if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + PtrW'(1);
  end

  assign rsp_head    = rsp_mem_q[rsp_rptr_q[AddrW-1:0]];
  assign o_rsp_valid = !rsp_empty;
  assign o_rsp_id    = rsp_head[17:16];
  assign o_rsp_y     = rsp_head[15:0];
  assign o_flush_done = flush_done_q;
  assign o_err        = err_q;

  // Flush FSM: leave drain in the cycle the count reaches zero and pulse done with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (i_flush) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (outstanding_d == '0) begin
            state_q      <= StRun;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Control state; last_grant resets to 3 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q         <= 1'b0;
      last_grant_q  <= 2'd3;
      outstanding_q <= '0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      rsp_wptr_q    <= '0;
      rsp_rptr_q    <= '0;
    end else begin
      err_q         <= err_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      tag_wptr_q    <= tag_wptr_d;
      tag_rptr_q    <= tag_rptr_d;
      rsp_wptr_q    <= rsp_wptr_d;
      rsp_rptr_q    <= rsp_rptr_d;
    end
  end

  // Queue storage; contents are meaningless once the pointers are cleared
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem_q[tag_wptr_q[AddrW-1:0]] <= grant_idx;
    end
    if (rsp_push) begin
      rsp_mem_q[rsp_wptr_q[AddrW-1:0]] <= {tag_mem_q[tag_rptr_q[AddrW-1:0]], i_sig_y};
    end
  end

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter. It acts as the sigmoid unit, returning each result one cycle
// after issue. A queue-based model predicts grants, responses, error and flush completion.
module tb_sigmoid_arbiter;

  localparam int unsigned DEPTH = 4;
`ifdef SIGARB_PRIORITY_EN
  localparam int unsigned PrioG2 = 0;
`else
  localparam int unsigned PrioG2 = 4;
`endif

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_x;
  logic        sig_in_valid, sig_out_valid;
  logic [7:0]  sig_x;
  logic [15:0] sig_y, rsp_y;
  logic        rsp_valid, rsp_ready, flush, flush_done, err;
  logic [1:0]  rsp_id;

  sigmoid_arbiter #(.DEPTH(DEPTH), .NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_x(req_x), .o_req_ready(req_ready),
    .o_sig_in_valid(sig_in_valid), .o_sig_x(sig_x),
    .i_sig_out_valid(sig_out_valid), .i_sig_y(sig_y),
    .o_rsp_valid(rsp_valid), .o_rsp_y(rsp_y), .o_rsp_id(rsp_id),
    .i_rsp_ready(rsp_ready), .i_flush(flush), .o_flush_done(flush_done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors, miscompares;

  // Reference model state
  int          m_last, m_out;
  int          m_tag[$];
  logic [17:0] m_rsp[$];
  bit          m_err, m_drain, m_done;

  // Expected values for the current cycle
  int          e_g;
  logic [3:0]  e_ready;
  logic        e_sv, e_rv, e_err, e_done;
  logic [7:0]  e_x;
  logic [15:0] e_y;
  logic [1:0]  e_id;

  // Sigmoid unit stub
  logic        nxt_sv;
  logic [15:0] nxt_y;
  bit          force_sov;

  function automatic logic [15:0] sig_f(input logic [7:0] x);
    int xs, v;
    xs = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    v  = 16384 + xs * 64;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_last = 3; m_out = 0; m_err = 0; m_drain = 0; m_done = 0;
    m_tag.delete();
    m_rsp.delete();
  endtask

  task automatic model_eval();
    int c;
    e_g = -1;
    if (!m_drain && m_out < DEPTH) begin
`ifdef SIGARB_PRIORITY_EN
      if (req_valid[0]) e_g = 0;
      else for (int i = 1; i <= 4; i++) begin
        c = (m_last + i) % 4;
        if (e_g < 0 && c != 0 && req_valid[c]) e_g = c;
      end
`else
      for (int i = 1; i <= 4; i++) begin
        c = (m_last + i) % 4;
        if (e_g < 0 && req_valid[c]) e_g = c;
      end
`endif
    end
    e_sv    = (e_g >= 0);
    e_ready = e_sv ? (4'b0001 << e_g) : 4'b0000;
    e_x     = e_sv ? req_x[8*e_g +: 8] : 8'h00;
    e_rv    = (m_rsp.size() != 0);
    {e_id, e_y} = e_rv ? m_rsp[0] : 18'h0;
    e_err   = m_err;
    e_done  = m_done;
  endtask

  task automatic model_commit();
    int t;
    bit pop;
    pop = e_rv && rsp_ready;
    if (pop) void'(m_rsp.pop_front());
    if (sig_out_valid) begin
      if (m_tag.size() == 0) m_err = 1;
      else begin
        t = m_tag.pop_front();
        m_rsp.push_back({2'(t), sig_y});
      end
    end
    if (e_g >= 0) begin
      m_tag.push_back(e_g);
      m_out++;
`ifdef SIGARB_PRIORITY_EN
      if (e_g != 0) m_last = e_g;
`else
      m_last = e_g;
`endif
    end
    if (pop) m_out--;
    m_done = 0;
    if (m_drain) begin
      if (m_out == 0) begin
        m_drain = 0;
        m_done  = 1;
      end
    end else if (flush) m_drain = 1;
  endtask

  // Called at the falling edge; returns 1 time unit after the next rising edge
  task automatic advance_raw();
    nxt_sv = sig_in_valid;
    nxt_y  = sig_f(sig_x);
    @(posedge clk);
    #1;
    sig_out_valid = force_sov | nxt_sv;
    sig_y         = force_sov ? 16'($urandom) : nxt_y;
  endtask

  task automatic advance();
    model_commit();
    advance_raw();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_x = $urandom; rsp_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0000 || sig_in_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_grant: ready=%b sig_in_valid=%b, required 0000/0", req_ready,
                 sig_in_valid);
      end
      vectors++;
      if (rsp_valid !== 1'b0 || err !== 1'b0 || flush_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: rsp_valid=%b err=%b done=%b, required 0/0/0", rsp_valid,
                 err, flush_done);
      end
      advance_raw();
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 16; k++) begin
      req_valid = 4'hF; req_x = 32'h0; rsp_ready = 1'b1; flush = 1'b0;
      model_eval();
      @(negedge clk);
      vectors++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        miscompares++;
        $display("FAIL rr_order cyc %0d: ready=%b required %b", k, req_ready,
                 4'b0001 << (k % 4));
      end
      vectors++;
      if (sig_in_valid !== 1'b1 || sig_x !== 8'h00) begin
        miscompares++;
        $display("FAIL rr_issue cyc %0d: valid=%b x=%h required 1/00", k, sig_in_valid, sig_x);
      end
      vectors++;
      if (rsp_valid !== e_rv) begin
        miscompares++;
        $display("FAIL rr_rsp_valid cyc %0d: got %b required %b", k, rsp_valid, e_rv);
      end
      if (e_rv) begin
        vectors++;
        if (rsp_id !== e_id || rsp_y !== 16'h4000) begin
          miscompares++;
          $display("FAIL rr_rsp cyc %0d: id=%0d y=%h required %0d/4000", k, rsp_id, rsp_y,
                   e_id);
        end
      end
      advance();
    end
  endtask

  task automatic test_idle_drain(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 4'h0; rsp_ready = 1'b1; flush = 1'b0;
      model_eval();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== e_rv || err !== e_err || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle cyc %0d: rsp_valid=%b err=%b ready=%b required %b/%b/0000", k,
                 rsp_valid, err, req_ready, e_rv, e_err);
      end
      if (e_rv) begin
        vectors++;
        if (rsp_id !== e_id || rsp_y !== e_y) begin
          miscompares++;
          $display("FAIL idle_rsp cyc %0d: id=%0d y=%h required %0d/%h", k, rsp_id, rsp_y,
                   e_id, e_y);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int grants;
    grants = 0;
    for (int k = 0; k < 18; k++) begin
      req_valid = 4'hF; req_x = $urandom; rsp_ready = (k >= 8); flush = 1'b0;
      model_eval();
      @(negedge clk);
      if (k < 8 && req_ready != 4'b0000) grants++;
      vectors++;
      if (req_ready !== e_ready || sig_x !== e_x) begin
        miscompares++;
        $display("FAIL bp_grant cyc %0d: ready=%b x=%h required %b/%h", k, req_ready, sig_x,
                 e_ready, e_x);
      end
      if (e_rv) begin
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== e_id || rsp_y !== e_y) begin
          miscompares++;
          $display("FAIL bp_rsp cyc %0d: v=%b id=%0d y=%h required 1/%0d/%h", k, rsp_valid,
                   rsp_id, rsp_y, e_id, e_y);
        end
      end
      advance();
    end
    vectors++;
    if (grants != DEPTH) begin
      miscompares++;
      $display("FAIL bp_grant_count: got %0d required %0d", grants, DEPTH);
    end
  endtask

  task automatic test_flush();
    int pulses;
    bit seen;
    // Build three outstanding samples
    for (int k = 0; k < 4; k++) begin
      req_valid = (k < 3) ? 4'hF : 4'h0; req_x = $urandom; rsp_ready = 1'b0;
      flush = (k == 3);
      model_eval();
      @(negedge clk);
      vectors++;
      if (req_ready !== e_ready) begin
        miscompares++;
        $display("FAIL flush_setup cyc %0d: ready=%b required %b", k, req_ready, e_ready);
      end
      advance();
    end
    pulses = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid = 4'hF; req_x = $urandom; rsp_ready = 1'b1; flush = 1'b0;
      model_eval();
      @(negedge clk);
      if (flush_done === 1'b1) begin
        pulses++;
        seen = 1;
      end
      vectors++;
      if (!seen && req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL flush_grant cyc %0d: ready=%b required 0000 while draining", k,
                 req_ready);
      end
      vectors++;
      if (flush_done !== e_done || req_ready !== e_ready) begin
        miscompares++;
        $display("FAIL flush_drain cyc %0d: done=%b ready=%b required %b/%b", k, flush_done,
                 req_ready, e_done, e_ready);
      end
      advance();
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL flush_pulses: got %0d required 1", pulses);
    end
    test_idle_drain(6);
    // Flush with nothing outstanding
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'h0; rsp_ready = 1'b1; flush = (k == 0);
      model_eval();
      @(negedge clk);
      if (flush_done === 1'b1) pulses++;
      vectors++;
      if (flush_done !== e_done) begin
        miscompares++;
        $display("FAIL flush_idle cyc %0d: done=%b required %b", k, flush_done, e_done);
      end
      advance();
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL flush_idle_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom); req_x = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 31) == 0);
      model_eval();
      @(negedge clk);
      vectors++;
      if (req_ready !== e_ready || sig_in_valid !== e_sv || (e_sv && sig_x !== e_x)) begin
        miscompares++;
        $display("FAIL rand_issue cyc %0d: ready=%b v=%b x=%h required %b/%b/%h", k,
                 req_ready, sig_in_valid, sig_x, e_ready, e_sv, e_x);
      end
      vectors++;
      if (rsp_valid !== e_rv || (e_rv && (rsp_id !== e_id || rsp_y !== e_y))) begin
        miscompares++;
        $display("FAIL rand_rsp cyc %0d: v=%b id=%0d y=%h required %b/%0d/%h", k, rsp_valid,
                 rsp_id, rsp_y, e_rv, e_id, e_y);
      end
      vectors++;
      if (flush_done !== e_done || err !== e_err) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc %0d: done=%b err=%b required %b/%b", k, flush_done, err,
                 e_done, e_err);
      end
      advance();
    end
  endtask

  task automatic test_priority();
    int g0, g2;
    g0 = 0; g2 = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b0101; req_x = $urandom; rsp_ready = 1'b1; flush = 1'b0;
      model_eval();
      @(negedge clk);
      if (req_ready === 4'b0001) g0++;
      if (req_ready === 4'b0100) g2++;
      vectors++;
      if (req_ready !== e_ready) begin
        miscompares++;
        $display("FAIL prio_grant cyc %0d: ready=%b required %b", k, req_ready, e_ready);
      end
      advance();
    end
    vectors++;
    if (g2 != PrioG2 || g0 != 8 - PrioG2) begin
      miscompares++;
      $display("FAIL prio_count: g0=%0d g2=%0d required %0d/%0d", g0, g2, 8 - PrioG2, PrioG2);
    end
  endtask

  task automatic test_err();
    force_sov = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) force_sov = 1'b0;
      req_valid = 4'h0; rsp_ready = 1'b1; flush = 1'b0;
      model_eval();
      @(negedge clk);
      vectors++;
      if (err !== e_err || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_sticky cyc %0d: err=%b rsp_valid=%b required %b/0", k, err,
                 rsp_valid, e_err);
      end
      advance();
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_final: got %b required 1", err);
    end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'hF; req_x = $urandom; rsp_ready = 1'b0; flush = 1'b0;
      model_eval();
      @(negedge clk);
      vectors++;
      if (req_ready !== e_ready) begin
        miscompares++;
        $display("FAIL midop_grant cyc %0d: ready=%b required %b", k, req_ready, e_ready);
      end
      advance();
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0000 || sig_in_valid !== 1'b0 || rsp_valid !== 1'b0 ||
        err !== 1'b0 || flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: ready=%b sv=%b rv=%b err=%b done=%b required all zero",
               req_ready, sig_in_valid, rsp_valid, err, flush_done);
    end
    advance_raw();
    rst = 1'b0;
    model_reset();
    req_valid = 4'h0;
    sig_out_valid = 1'b1;
    sig_y = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      model_eval();
      @(negedge clk);
      vectors++;
      if (err !== e_err || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_late cyc %0d: err=%b rsp_valid=%b required %b/0", k, err,
                 rsp_valid, e_err);
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; force_sov = 1'b0;
    rst = 1'b1; req_valid = 4'h0; req_x = 32'h0; rsp_ready = 1'b0; flush = 1'b0;
    sig_out_valid = 1'b0; sig_y = 16'h0; nxt_sv = 1'b0; nxt_y = 16'h0;
    model_reset();
    test_reset();
    test_round_robin();
    test_idle_drain(6);
    test_backpressure();
    test_idle_drain(8);
    test_flush();
    test_random();
    test_idle_drain(12);
    test_priority();
    test_idle_drain(6);
    test_err();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
